// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Load-and-run controller for instruction_fetch. Collects a
//               byte stream (MSB first) from the debug UART receiver into
//               32-bit words and writes them sequentially into instruction
//               memory. The load ends on the EOF word 32'hFFFF_FFFF or when
//               MEM_DEPTH words have been written. The fetch PC is then reset
//               and the pipeline runs until halt is reported.
//
// Parameters  : MEM_DEPTH  instruction memory size in words (power of 2, >=4)
//               START_CMD  command byte that begins a load
// Ports       : clk                           system clock, rising edge
//               reset                         asynchronous, active-low
//               rx_data / rx_valid            received byte and its strobe
//               halt                          pipeline halt (level)
//               step                          single-step pulse
//               wr_memory_instruction_enable  memory write strobe
//               instruction_to_write          word written
//               address_to_write              byte address written
//               fetch_reset                   one-cycle PC reset pulse
//               mips_enable / pc_enable       pipeline / PC enables
//               loaded_words                  words written by last load
//               overflow                      sticky: load hit MEM_DEPTH
// Option      : STEP_MODE_EN  when defined, pc_enable in RUN is high only
//               for the cycle after each step pulse.
// Revision    : 1.0  initial release
// ============================================================================
module instruction_loader #(
    parameter int         MEM_DEPTH = 256,
    parameter logic [7:0] START_CMD = 8'h4C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        halt,
    input  logic        step,
    output logic        wr_memory_instruction_enable,
    output logic [31:0] instruction_to_write,
    output logic [31:0] address_to_write,
    output logic        fetch_reset,
    output logic        mips_enable,
    output logic        pc_enable,
    output logic [31:0] loaded_words,
    output logic        overflow
);

    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_load   = 3'd1;
    localparam logic [2:0]  c_st_write  = 3'd2;
    localparam logic [2:0]  c_st_boot   = 3'd3;
    localparam logic [2:0]  c_st_run    = 3'd4;
    localparam logic [2:0]  c_st_halted = 3'd5;

    localparam logic [31:0] c_mem_depth = 32'(MEM_DEPTH);
    localparam logic [31:0] c_eof_word  = 32'hFFFF_FFFF;

    logic [2:0]  r_state;
    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_addr;
    logic        r_eof;

    logic        w_start;
    logic [31:0] w_next_word;
    logic [31:0] w_words_after;

    assign w_start       = rx_valid && (rx_data == START_CMD);
    assign w_next_word   = {r_word[23:0], rx_data};
    assign w_words_after = loaded_words + 32'd1;

`ifndef STEP_MODE_EN
    logic w_step_unused;
    assign w_step_unused = step;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                      <= c_st_idle;
            r_word                       <= 32'd0;
            r_byte_cnt                   <= 2'd0;
            r_addr                       <= 32'd0;
            r_eof                        <= 1'b0;
            wr_memory_instruction_enable <= 1'b0;
            instruction_to_write         <= 32'd0;
            address_to_write             <= 32'd0;
            fetch_reset                  <= 1'b0;
            mips_enable                  <= 1'b0;
            pc_enable                    <= 1'b0;
            loaded_words                 <= 32'd0;
            overflow                     <= 1'b0;
        end else begin
            // Strobe-type outputs default low; they are raised for one cycle.
            wr_memory_instruction_enable <= 1'b0;
            fetch_reset                  <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    r_addr       <= 32'd0;
                    loaded_words <= 32'd0;
                    overflow     <= 1'b0;
                    r_byte_cnt   <= 2'd0;
                    mips_enable  <= 1'b0;
                    pc_enable    <= 1'b0;
                    if (w_start) begin
                        r_state <= c_st_load;
                    end
                end

                c_st_load: begin
                    if (rx_valid) begin
                        r_word     <= w_next_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Decide EOF here so the strobe is already
                            // registered for the WRITE cycle.
                            r_state <= c_st_write;
                            r_eof   <= (w_next_word == c_eof_word);
                            if (w_next_word != c_eof_word) begin
                                wr_memory_instruction_enable <= 1'b1;
                                instruction_to_write         <= w_next_word;
                                address_to_write             <= r_addr;
                            end
                        end
                    end
                end

                c_st_write: begin
                    if (r_eof) begin
                        r_state     <= c_st_boot;
                        fetch_reset <= 1'b1;
                    end else begin
                        r_addr       <= r_addr + 32'd4;
                        loaded_words <= w_words_after;
                        if (w_words_after == c_mem_depth) begin
                            overflow    <= 1'b1;
                            r_state     <= c_st_boot;
                            fetch_reset <= 1'b1;
                        end else begin
                            r_state <= c_st_load;
                            // A byte arriving now is byte 0 of the next word.
                            if (rx_valid) begin
                                r_word     <= {24'd0, rx_data};
                                r_byte_cnt <= 2'd1;
                            end
                        end
                    end
                end

                c_st_boot: begin
                    r_state     <= c_st_run;
                    mips_enable <= 1'b1;
`ifdef STEP_MODE_EN
                    pc_enable   <= 1'b0;
`else
                    pc_enable   <= 1'b1;
`endif
                end

                c_st_run: begin
                    if (halt) begin
                        r_state     <= c_st_halted;
                        mips_enable <= 1'b0;
                        pc_enable   <= 1'b0;
                    end else begin
`ifdef STEP_MODE_EN
                        pc_enable <= step;
`else
                        pc_enable <= 1'b1;
`endif
                    end
                end

                c_st_halted: begin
                    mips_enable <= 1'b0;
                    pc_enable   <= 1'b0;
                    if (w_start) begin
                        r_state      <= c_st_load;
                        r_addr       <= 32'd0;
                        loaded_words <= 32'd0;
                        overflow     <= 1'b0;
                        r_byte_cnt   <= 2'd0;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed self-checking bench for instruction_loader
//               (MEM_DEPTH = 4) with hand-computed expected values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic        step;
    logic        wr_memory_instruction_enable;
    logic [31:0] instruction_to_write;
    logic [31:0] address_to_write;
    logic        fetch_reset;
    logic        mips_enable;
    logic        pc_enable;
    logic [31:0] loaded_words;
    logic        overflow;

    int total;
    int bad;

    // Write and fetch_reset log, sampled on the falling edge.
    logic [31:0] wlog_data [0:31];
    logic [31:0] wlog_addr [0:31];
    int          nw;
    int          fr_cnt;

    instruction_loader #(
        .MEM_DEPTH (4),
        .START_CMD (8'h4C)
    ) u_dut (
        .clk                          (clk),
        .reset                        (reset),
        .rx_data                      (rx_data),
        .rx_valid                     (rx_valid),
        .halt                         (halt),
        .step                         (step),
        .wr_memory_instruction_enable (wr_memory_instruction_enable),
        .instruction_to_write         (instruction_to_write),
        .address_to_write             (address_to_write),
        .fetch_reset                  (fetch_reset),
        .mips_enable                  (mips_enable),
        .pc_enable                    (pc_enable),
        .loaded_words                 (loaded_words),
        .overflow                     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        nw     = 0;
        fr_cnt = 0;
    end

    always @(negedge clk) begin
        if (wr_memory_instruction_enable && nw < 32) begin
            wlog_data[nw] = instruction_to_write;
            wlog_addr[nw] = address_to_write;
            nw = nw + 1;
        end
        if (fetch_reset) fr_cnt = fr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns 1 time unit after its edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        send_byte(t[31:24]);
        send_byte(t[23:16]);
        send_byte(t[15:8]);
        send_byte(t[7:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc_cnt;
        int me_cnt;
        int nw_snap;
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        halt     = 1'b0;
        step     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", {31'd0, wr_memory_instruction_enable}, 32'd0);
        chk("rst_instr", instruction_to_write, 32'd0);
        chk("rst_addr", address_to_write, 32'd0);
        chk("rst_fr", {31'd0, fetch_reset}, 32'd0);
        chk("rst_mips", {31'd0, mips_enable}, 32'd0);
        chk("rst_pc", {31'd0, pc_enable}, 32'd0);
        chk("rst_lw", loaded_words, 32'd0);
        chk("rst_ov", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        tick();

        // Load and run: two words then EOF
        send_byte(8'h4C);
        send_word(32'h2008_0005);
        chk("w0_strobe", {31'd0, wr_memory_instruction_enable}, 32'd1);
        chk("w0_data", instruction_to_write, 32'h2008_0005);
        chk("w0_addr", address_to_write, 32'h0);
        tick();
        chk("w0_strobe_drop", {31'd0, wr_memory_instruction_enable}, 32'd0);
        chk("w0_lw", loaded_words, 32'd1);
        send_word(32'h0000_0000);
        chk("w1_strobe", {31'd0, wr_memory_instruction_enable}, 32'd1);
        chk("w1_data", instruction_to_write, 32'h0);
        chk("w1_addr", address_to_write, 32'h4);
        tick();
        send_word(32'hFFFF_FFFF);
        chk("eof_no_write", {31'd0, wr_memory_instruction_enable}, 32'd0);
        tick();
        chk("boot_fr", {31'd0, fetch_reset}, 32'd1);
        chk("boot_mips", {31'd0, mips_enable}, 32'd0);
        tick();
        chk("run_mips", {31'd0, mips_enable}, 32'd1);
        chk("run_fr", {31'd0, fetch_reset}, 32'd0);
        chk("run1_lw", loaded_words, 32'd2);
        chk("run1_ov", {31'd0, overflow}, 32'd0);
        chk("run1_nw", nw, 32'd2);
        chk("run1_frcnt", fr_cnt, 32'd1);
`ifdef STEP_MODE_EN
        chk("run1_pc", {31'd0, pc_enable}, 32'd0);
`else
        chk("run1_pc", {31'd0, pc_enable}, 32'd1);
`endif

        // RUN ignores received bytes; enables over 12 cycles
        send_byte(8'h4C);
        pc_cnt = 0;
        me_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step = (i == 1 || i == 5 || i == 9);
            tick();
            step = 1'b0;
            if (pc_enable) pc_cnt = pc_cnt + 1;
            if (mips_enable) me_cnt = me_cnt + 1;
        end
`ifdef STEP_MODE_EN
        chk("step_pc_pulses", pc_cnt, 32'd3);
`else
        chk("run_pc_high", pc_cnt, 32'd12);
`endif
        chk("run_mips_high", me_cnt, 32'd12);
        chk("run_rx_ignored_nw", nw, 32'd2);

        // Halt together with START_CMD: halt wins
        halt     = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h4C;
        tick();
        halt     = 1'b0;
        rx_valid = 1'b0;
        chk("halt_mips", {31'd0, mips_enable}, 32'd0);
        chk("halt_pc", {31'd0, pc_enable}, 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("halt_step_pc", {31'd0, pc_enable}, 32'd0);

        // Reload one word
        send_byte(8'h4C);
        send_word(32'hAABB_CCDD);
        chk("rl_data", instruction_to_write, 32'hAABB_CCDD);
        chk("rl_addr", address_to_write, 32'h0);
        chk("rl_lw_cleared", loaded_words, 32'd0);
        tick();
        send_word(32'hFFFF_FFFF);
        tick();
        tick();
        chk("rl_mips", {31'd0, mips_enable}, 32'd1);
        chk("rl_lw", loaded_words, 32'd1);
        chk("rl_nw", nw, 32'd3);

        // Overflow at MEM_DEPTH=4 with back-to-back bytes
        halt = 1'b1;
        tick();
        halt = 1'b0;
        send_byte(8'h4C);
        for (int i = 1; i <= 20; i++) begin
            send_byte(8'(i));
        end
        chk("ov_mips", {31'd0, mips_enable}, 32'd1);
        chk("ov_flag", {31'd0, overflow}, 32'd1);
        chk("ov_lw", loaded_words, 32'd4);
        chk("ov_nw", nw, 32'd7);
        chk("ov_d0", wlog_data[3], 32'h0102_0304);
        chk("ov_d1", wlog_data[4], 32'h0506_0708);
        chk("ov_d2", wlog_data[5], 32'h090A_0B0C);
        chk("ov_d3", wlog_data[6], 32'h0D0E_0F10);
        chk("ov_a1", wlog_addr[4], 32'h4);
        chk("ov_a3", wlog_addr[6], 32'hC);
        chk("ov_frcnt", fr_cnt, 32'd3);

        // Asynchronous reset while running
        #3;
        reset = 1'b0;
        #1;
        chk("arst_mips", {31'd0, mips_enable}, 32'd0);
        chk("arst_ov", {31'd0, overflow}, 32'd0);
        chk("arst_lw", loaded_words, 32'd0);
        tick();
        reset = 1'b1;

        // Asynchronous reset after two bytes of a word
        send_byte(8'h4C);
        send_byte(8'h0A);
        send_byte(8'h0B);
        #3;
        reset = 1'b0;
        #1;
        chk("arst2_wr", {31'd0, wr_memory_instruction_enable}, 32'd0);
        chk("arst2_instr", instruction_to_write, 32'd0);
        tick();
        reset = 1'b1;
        nw_snap = nw;
        send_word(32'h0000_0000);
        tick();
        chk("idle_noise_nw", nw - nw_snap, 32'd0);

        // Fresh load after reset starts at address 0 with a clean byte count
        send_byte(8'h4C);
        send_word(32'h1234_5678);
        chk("post_rst_data", instruction_to_write, 32'h1234_5678);
        chk("post_rst_addr", address_to_write, 32'h0);
        chk("post_rst_strobe", {31'd0, wr_memory_instruction_enable}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
# instruction_loader

Load-and-run controller for `instruction_fetch`. It assembles a byte stream from the debug UART receiver into 32-bit instruction words and writes them sequentially into instruction memory through the fetch stage's write port. The load ends on the end-of-file word 32'hFFFF_FFFF or when memory is full. The block then resets the fetch stage's PC and releases the pipeline with `mips_enable`/`pc_enable`, keeping it running until a halt is reported.

## Interface
- `MEM_DEPTH`, 256: instruction memory size in 32-bit words (power of two, ≥4).
- `START_CMD`, 8'h4C: command byte that begins a load.
- `clk`  in  1  system clock; everything sampled on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `halt`  in  1  pipeline halt indication, level-sensitive.
- `step`  in  1  single-step request, one-cycle pulse; used only with `STEP_MODE_EN`.
- `wr_memory_instruction_enable`  out  1  instruction memory write strobe.
- `instruction_to_write`  out  32  word to write.
- `address_to_write`  out  32  byte address of the write.
- `fetch_reset`  out  1  active-high PC reset pulse to `instruction_fetch`.
- `mips_enable`  out  1  pipeline enable.
- `pc_enable`  out  1  PC advance enable.
- `loaded_words`  out  32  words written by the last load.
- `overflow`  out  1  sticky flag: the load was truncated at `MEM_DEPTH`.

## Operation
- All outputs are registered. While `reset`=0, every output is 0 and the state is IDLE.
- **IDLE**
  - `rx_valid` with `rx_data`==`START_CMD` → LOAD.
  - Clears the address, `loaded_words`, `overflow` and the byte counter.
  - All other bytes are ignored.
- **LOAD**
  - Each `rx_valid` shifts `rx_data` into the word, MSB first, and increments the 2-bit byte counter.
  - On the 4th byte → WRITE.
- **WRITE** (exactly one cycle)
  - If word==32'hFFFF_FFFF: no write, → BOOT.
  - Otherwise, for one cycle: `wr_memory_instruction_enable`=1, `instruction_to_write`=word, `address_to_write`=addr.
  - Then addr += 4 and `loaded_words` += 1.
  - If `loaded_words` reaches `MEM_DEPTH` after this write: `overflow`=1, → BOOT. Otherwise → LOAD.
  - An `rx_valid` in the WRITE cycle is kept as byte 0 of the next word (byte counter=1). In the overflow and EOF cases it is dropped.
- **BOOT** (one cycle): `fetch_reset`=1, `mips_enable`=0, `pc_enable`=0 → RUN.
- **RUN**
  - `mips_enable`=1 and `pc_enable`=1.
  - `halt`=1 → HALTED; both enables drop on the next edge.
  - `rx_valid` bytes are ignored.
- **HALTED**
  - `mips_enable`=0, `pc_enable`=0.
  - `START_CMD` → LOAD: address, `loaded_words` and `overflow` are cleared, and a fresh load starts at address 0.
- Address arithmetic is 32-bit with no wrap. The maximum address written is 4·(`MEM_DEPTH`−1).

## Timing
- Latency from the 4th byte's `rx_valid` edge to the write strobe is 1 cycle. The strobe is high for exactly 1 cycle.
- The EOF byte's edge is followed by WRITE (1 cycle), then BOOT (1 cycle), so `mips_enable` rises 3 edges after the EOF byte's `rx_valid`.
- `fetch_reset` is high for exactly one cycle, immediately before `mips_enable` rises.
- `halt` and `START_CMD` arriving in the same RUN cycle: `halt` wins, and the byte is ignored.
- Asynchronous reset mid-load or mid-run returns to IDLE immediately. Memory contents are untouched.

## Configuration
- `STEP_MODE_EN`
  - **Defined:** in RUN, `mips_enable`=1 but `pc_enable` is high only for the single cycle after each `step` pulse. A `step` while HALTED is ignored.
  - **Undefined:** `step` is unused and `pc_enable` stays high throughout RUN.

## Test plan
- **Load and run.** Send 4C, then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF.
  - Two write strobes: (0x20080005 @ 0x0) and (0x00000000 @ 0x4).
  - `loaded_words`=2, `overflow`=0.
  - `fetch_reset` pulses once, then `mips_enable`=1.
- **Overflow.** With `MEM_DEPTH`=4, send 4C and then 5 words.
  - Four writes at 0x0–0xC.
  - `overflow`=1, RUN is entered, the 5th word is never written.
- **Back-to-back byte.** Assert `rx_valid` in the WRITE cycle.
  - That byte becomes the MSB of the next word.
  - The next write carries the correct value at addr+4.
- **Reset and noise.** Deassert `reset` after 2 bytes of a word.
  - All outputs 0 immediately.
  - A later byte 0x00 in IDLE causes no write.
- **Halt and reload.** Raise `halt` in RUN.
  - `mips_enable` falls on the next edge.
  - Sending 4C + 1 word + EOF rewrites address 0x0.
  - `loaded_words`=1.
- **Step mode** (`STEP_MODE_EN`). In RUN, send 3 `step` pulses.
  - Exactly 3 single-cycle `pc_enable` pulses.
  - `mips_enable` stays high throughout.
